// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception state, MTC0/MFC0 access and Count/Compare timer.
// Optional build macro CP0_IDREGS_EN adds read-only PRId (15) and Config (16).
`ifndef ExcT
`define ExcT        3:0
`define ExcT_Intr   4'h0
`define ExcT_AdEL1  4'h1
`define ExcT_AdEL2  4'h2
`define ExcT_AdES   4'h3
`define ExcT_SysC   4'h4
`define ExcT_Bp     4'h5
`define ExcT_RI     4'h6
`define ExcT_Ov     4'h7
`define ExcT_ERET   4'h8
`endif

module cp0_regfile #(
  parameter int         HW_INT_W   = 6,
  parameter logic [0:0] STATUS_BEV = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          raddr_i,
  output logic [31:0]         rdata_o,
  input  logic [HW_INT_W-1:0] hw_int_i,
  input  logic                exc_flag_i,
  input  logic [`ExcT]        exc_type_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                exc_bd_i,
  input  logic [31:0]         exc_baddr_i,
  output logic [31:0]         epc_o,
  output logic [31:0]         errorepc_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic                intr_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_ERROREPC = 5'd30;

  logic [31:0] badvaddr, count, compare, epc, errorepc;
  logic        tick, ti, bd, exl, ie;
  logic [7:0]  im;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [4:0]  exc_code;

  logic        wr, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_errorepc;
  logic        inc, ti_set, ti_nxt, is_eret, is_ade;
  logic [4:0]  exc_code_nxt;

  // The excepting instruction's MTC0 is squashed, so exc_flag_i masks every write.
  always_comb begin
    wr          = we_i & ~exc_flag_i;
    wr_count    = wr && (waddr_i == REG_COUNT);
    wr_compare  = wr && (waddr_i == REG_COMPARE);
    wr_status   = wr && (waddr_i == REG_STATUS);
    wr_cause    = wr && (waddr_i == REG_CAUSE);
    wr_epc      = wr && (waddr_i == REG_EPC);
    wr_errorepc = wr && (waddr_i == REG_ERROREPC);
    inc         = tick & ~wr_count;
    ti_set      = inc && ((count + 32'd1) == compare);
    ti_nxt      = wr_compare ? 1'b0 : (ti | ti_set);
    is_eret     = (exc_type_i == `ExcT_ERET);
    is_ade      = (exc_type_i == `ExcT_AdEL1) || (exc_type_i == `ExcT_AdEL2) ||
                  (exc_type_i == `ExcT_AdES);
  end

  always_comb begin
    exc_code_nxt = 5'h00;
    case (exc_type_i)
      `ExcT_AdEL1, `ExcT_AdEL2: exc_code_nxt = 5'h04;
      `ExcT_AdES:               exc_code_nxt = 5'h05;
      `ExcT_SysC:               exc_code_nxt = 5'h08;
      `ExcT_Bp:                 exc_code_nxt = 5'h09;
      `ExcT_RI:                 exc_code_nxt = 5'h0A;
      `ExcT_Ov:                 exc_code_nxt = 5'h0C;
      default:                  exc_code_nxt = 5'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      errorepc <= '0;
      tick     <= 1'b0;
      ti       <= 1'b0;
      bd       <= 1'b0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      im       <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
      exc_code <= '0;
    end else begin
      tick <= wr_count ? 1'b0 : ~tick;
      if (wr_count)  count <= wdata_i;
      else if (tick) count <= count + 32'd1;
      if (wr_compare) compare <= wdata_i;
      ti    <= ti_nxt;
      ip_hw <= {hw_int_i[5] | ti_nxt, hw_int_i[4:0]};
      if (wr_status) begin
        im  <= wdata_i[15:8];
        exl <= wdata_i[1];
        ie  <= wdata_i[0];
      end
      if (wr_cause)    ip_sw    <= wdata_i[9:8];
      if (wr_epc)      epc      <= wdata_i;
      if (wr_errorepc) errorepc <= wdata_i;
      if (exc_flag_i) begin
        if (is_eret) begin
          exl <= 1'b0;
        end else begin
          // Nested exceptions keep the original return point.
          if (!exl) begin
            epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
            bd  <= exc_bd_i;
          end
          exl      <= 1'b1;
          exc_code <= exc_code_nxt;
          if (is_ade) badvaddr <= exc_baddr_i;
        end
      end
    end
  end

  assign status_o   = {9'b0, STATUS_BEV, 6'b0, im, 6'b0, exl, ie};
  assign cause_o    = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
  assign epc_o      = epc;
  assign errorepc_o = errorepc;
  assign intr_o     = (|({ip_hw, ip_sw} & im)) & ie & ~exl;

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr;
      REG_COUNT:    rdata_o = count;
      REG_COMPARE:  rdata_o = compare;
      REG_STATUS:   rdata_o = status_o;
      REG_CAUSE:    rdata_o = cause_o;
      REG_EPC:      rdata_o = epc;
      REG_ERROREPC: rdata_o = errorepc;
`ifdef CP0_IDREGS_EN
      5'd15:        rdata_o = 32'h0000_4220;
      5'd16:        rdata_o = 32'h8000_8000;
`endif
      default:      rdata_o = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[31:16], wdata_i[7:2]};

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic
// compared every cycle against a field-level reference model.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst, we_i, exc_flag_i, exc_bd_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] wdata_i, exc_pc_i, exc_baddr_i;
  logic [5:0]  hw_int_i;
  logic [3:0]  exc_type_i;
  logic [31:0] rdata_o, epc_o, errorepc_o, status_o, cause_o;
  logic        intr_o;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] T_INTR = 4'd0, T_ADEL1 = 4'd1, T_ADEL2 = 4'd2, T_ADES = 4'd3,
                         T_SYSC = 4'd4, T_BP = 4'd5, T_RI = 4'd6, T_OV = 4'd7, T_ERET = 4'd8;

  cp0_regfile #(.HW_INT_W(6), .STATUS_BEV(1'b1)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
    .exc_flag_i(exc_flag_i), .exc_type_i(exc_type_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_baddr_i(exc_baddr_i), .epc_o(epc_o),
    .errorepc_o(errorepc_o), .status_o(status_o), .cause_o(cause_o), .intr_o(intr_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural fields only.
  logic [31:0] m_badv, m_count, m_compare, m_epc, m_errorepc;
  logic        m_half, m_ti, m_bd, m_exl, m_ie;
  logic [7:0]  m_im, m_ip;
  logic [4:0]  m_code;
  int          code_tbl [9] = '{0, 4, 4, 5, 8, 9, 10, 12, 0};

  function automatic logic [31:0] m_status();
    return (32'd1 << 22) | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic m_intr();
    return ((m_ip & m_im) != 8'h00) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd30: return m_errorepc;
`ifdef CP0_IDREGS_EN
      5'd15: return 32'h0000_4220;
      5'd16: return 32'h8000_8000;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    logic        wr, fire;
    logic [31:0] next_count;
    if (rst) begin
      m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_errorepc = 0;
      m_half = 0; m_ti = 0; m_bd = 0; m_exl = 0; m_ie = 0; m_im = 0; m_ip = 0; m_code = 0;
      return;
    end
    wr = we_i && !exc_flag_i;
    fire = 0;
    if (wr && waddr_i == 9) begin
      m_count = wdata_i;
      m_half  = 0;
    end else begin
      if (m_half) begin
        next_count = m_count + 32'd1;
        fire = (next_count == m_compare);
        m_count = next_count;
      end
      m_half = !m_half;
    end
    if (wr && waddr_i == 11) begin
      m_compare = wdata_i;
      m_ti = 0;
    end else if (fire) begin
      m_ti = 1;
    end
    if (wr && waddr_i == 12) begin
      m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0];
    end
    if (wr && waddr_i == 13) m_ip[1:0] = wdata_i[9:8];
    if (wr && waddr_i == 14) m_epc = wdata_i;
    if (wr && waddr_i == 30) m_errorepc = wdata_i;
    if (exc_flag_i) begin
      if (exc_type_i == T_ERET) m_exl = 0;
      else begin
        if (!m_exl) begin
          m_epc = exc_bd_i ? exc_pc_i - 4 : exc_pc_i;
          m_bd  = exc_bd_i;
        end
        m_exl  = 1;
        m_code = 5'(code_tbl[exc_type_i]);
        if (exc_type_i inside {T_ADEL1, T_ADEL2, T_ADES}) m_badv = exc_baddr_i;
      end
    end
    m_ip[7:2] = {hw_int_i[5] | m_ti, hw_int_i[4:0]};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("status", status_o, m_status());
    chk("cause", cause_o, m_cause());
    chk("epc", epc_o, m_epc);
    chk("errorepc", errorepc_o, m_errorepc);
    chk("intr", 32'(intr_o), 32'(m_intr()));
    chk("rdata", rdata_o, m_read(raddr_i));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; wdata_i = d;
    step();
    we_i = 0;
  endtask

  task automatic exc(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] ba,
                     input logic bd);
    exc_flag_i = 1; exc_type_i = t; exc_pc_i = pc; exc_baddr_i = ba; exc_bd_i = bd;
    step();
    exc_flag_i = 0;
  endtask

  initial begin
    int n;
    rst = 1; we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 5'd9; hw_int_i = 0;
    exc_flag_i = 0; exc_type_i = 0; exc_pc_i = 0; exc_bd_i = 0; exc_baddr_i = 0;
    idle(2);
    rst = 0;
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_intr", 32'(intr_o), 32'h0);
    chk("rst_count", rdata_o, 32'h0);
    idle(10);
    chk("count_half_rate", rdata_o, 32'd5);

    // Compare match raises TI and the timer interrupt.
    mtc0(9, 0);
    mtc0(11, 3);
    mtc0(12, 32'h0000_8001);
    n = 0;
    while (cause_o[30] !== 1'b1 && n < 20) begin step(); n++; end
    chk("ti_set", 32'(cause_o[30]), 32'h1);
    chk("ti_count", rdata_o, 32'd3);
    chk("ti_intr", 32'(intr_o), 32'h1);
    mtc0(11, 32'hFFFF_0000);
    chk("ti_clear", 32'(cause_o[30]), 32'h0);
    chk("ti_clear_intr", 32'(intr_o), 32'h0);

    // Count wraps to zero and matches Compare = 0.
    mtc0(9, 32'hFFFF_FFFF);
    mtc0(11, 32'h0);
    idle(1);
    chk("wrap_count", rdata_o, 32'h0);
    chk("wrap_ti", 32'(cause_o[30]), 32'h1);

    // A Compare write on the matching cycle wins over the set.
    mtc0(11, 6);
    mtc0(9, 5);
    idle(1);
    mtc0(11, 6);
    chk("clr_beats_set_count", rdata_o, 32'd6);
    chk("clr_beats_set_ti", 32'(cause_o[30]), 32'h0);
    mtc0(11, 32'hFFFF_0000);
    mtc0(12, 32'h0);

    // Exceptions, nesting and ERET.
    exc(T_ADEL1, 32'hBFC0_0100, 32'hBFC0_0102, 1);
    chk("adel_epc", epc_o, 32'hBFC0_00FC);
    chk("adel_cause", cause_o, 32'h8000_0010);
    chk("adel_exl", 32'(status_o[1]), 32'h1);
    raddr_i = 5'd8;
    #1 chk("adel_badv", rdata_o, 32'hBFC0_0102);
    exc(T_SYSC, 32'hBFC0_0380, 32'h0, 0);
    chk("nest_epc", epc_o, 32'hBFC0_00FC);
    chk("nest_code", 32'(cause_o[6:2]), 32'h08);
    exc(T_ERET, 32'h0, 32'h0, 0);
    chk("eret_exl", 32'(status_o[1]), 32'h0);
    chk("eret_epc", epc_o, 32'hBFC0_00FC);

    // MTC0 in the excepting cycle is squashed.
    we_i = 1; waddr_i = 14; wdata_i = 32'h1234;
    exc(T_OV, 32'h8000_0010, 32'h0, 0);
    we_i = 0;
    chk("squash_epc", epc_o, 32'h8000_0010);
    chk("squash_code", 32'(cause_o[6:2]), 32'h0C);
    exc(T_ERET, 32'h0, 32'h0, 0);

    // Hardware interrupt gated by IM, IE and EXL.
    hw_int_i = 6'b000001;
    mtc0(12, 32'h0000_0401);
    chk("hw_intr_on", 32'(intr_o), 32'h1);
    mtc0(12, 32'h0000_0403);
    chk("hw_intr_exl", 32'(intr_o), 32'h0);
    hw_int_i = 0;

    raddr_i = 5'd15;
`ifdef CP0_IDREGS_EN
    #1 chk("prid", rdata_o, 32'h0000_4220);
`else
    #1 chk("reg15_unmapped", rdata_o, 32'h0);
`endif

    // Randomized traffic, including occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] addrs [11];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd30, 5'd15, 5'd16, 5'd3, 5'd0};
      addrs[10] = 5'($urandom);
      rst        = ($urandom_range(0, 99) == 0);
      we_i       = ($urandom_range(0, 2) == 0);
      waddr_i    = addrs[$urandom_range(0, 10)];
      wdata_i    = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1) wdata_i = m_count + 32'($urandom_range(0, 3));
      raddr_i    = addrs[$urandom_range(0, 10)];
      exc_flag_i = ($urandom_range(0, 7) == 0);
      exc_type_i = 4'($urandom_range(0, 8));
      exc_pc_i   = $urandom;
      exc_baddr_i = $urandom;
      exc_bd_i   = 1'($urandom);
      if ($urandom_range(0, 15) == 0) hw_int_i = 6'($urandom);
      step();
    end
    rst = 0; we_i = 0; exc_flag_i = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
